// File: rtl/rfphoenix_mcalu_issue_pkg.sv
// Shared types for the multicycle ALU issue/writeback sequencer.
// Provides the instruction/value/thread-id types, the opcode and function
// codes the classifier recognises, the multicycle class enum with its
// latencies, and the classification, latency and select-key helpers.
package rfphoenix_mcalu_issue_pkg;

   typedef logic [31:0] Value;
   typedef logic [3:0]  Tid;
   typedef logic [4:0]  McLat;
   typedef logic [19:0] McKey;

   typedef struct packed {
      logic [7:0] func;
      logic [5:0] Rb;
      logic [5:0] Ra;
      logic [5:0] Rt;
      logic [5:0] opcode;
   } Instruction;

   localparam logic [5:0] OP_R1   = 6'h01;
   localparam logic [5:0] OP_R2   = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h04;
   localparam logic [5:0] OP_MULI = 6'h06;
   localparam logic [5:0] OP_FMA  = 6'h10;
   localparam logic [5:0] OP_FMS  = 6'h11;
   localparam logic [5:0] OP_FNMA = 6'h12;
   localparam logic [5:0] OP_FNMS = 6'h13;

   localparam logic [7:0] FN_ADD      = 8'h04;
   localparam logic [7:0] FN_MUL      = 8'h06;
   localparam logic [7:0] FN_FADD     = 8'h20;
   localparam logic [7:0] FN_FSUB     = 8'h21;
   localparam logic [7:0] FN_FMUL     = 8'h22;
   localparam logic [7:0] FN_I2F      = 8'h30;
   localparam logic [7:0] FN_F2I      = 8'h31;
   localparam logic [7:0] FN_FTRUNC   = 8'h32;
   localparam logic [7:0] FN_FRSQRTE  = 8'h40;
   localparam logic [7:0] FN_FRES     = 8'h41;
   localparam logic [7:0] FN_FSIGMOID = 8'h42;

   typedef enum logic [2:0] {MC_NONE, MC_MUL, MC_FMA, MC_CVT, MC_EST} McClass;

   localparam McLat MCALU_LAT_MUL = 5'd8;
   localparam McLat MCALU_LAT_FMA = 5'd8;
   localparam McLat MCALU_LAT_CVT = 5'd8;
   localparam McLat MCALU_LAT_EST = 5'd6;

   function automatic McClass mcalu_class(input Instruction ir);
      McClass c;
      c = MC_NONE;
      case (ir.opcode)
         OP_MULI: c = MC_MUL;
         OP_FMA, OP_FMS, OP_FNMA, OP_FNMS: c = MC_FMA;
         OP_R2:
            case (ir.func)
               FN_MUL: c = MC_MUL;
               FN_FADD, FN_FSUB, FN_FMUL: c = MC_FMA;
               default: c = MC_NONE;
            endcase
         OP_R1:
            case (ir.func)
               FN_I2F, FN_F2I, FN_FTRUNC: c = MC_CVT;
               FN_FRSQRTE, FN_FRES, FN_FSIGMOID: c = MC_EST;
               default: c = MC_NONE;
            endcase
         default: c = MC_NONE;
      endcase
      return c;
   endfunction

   // MC_NONE reports zero: such ops never enter the tracking register.
   function automatic McLat mcalu_lat(input McClass c);
      McLat l;
      case (c)
         MC_MUL:  l = MCALU_LAT_MUL;
         MC_FMA:  l = MCALU_LAT_FMA;
         MC_CVT:  l = MCALU_LAT_CVT;
         MC_EST:  l = MCALU_LAT_EST;
         default: l = 5'd0;
      endcase
      return l;
   endfunction

   // Key driving the ALU output mux selection.
   function automatic McKey mcalu_key(input Instruction ir);
      return {ir.opcode, ir.func, ir.Rb};
   endfunction

endpackage

// File: rtl/rfphoenix_mcalu_issue_tag_shreg.sv
// rfphoenix_tag_shreg: LAT_MAX-deep shift register of {valid, tid, rd}
// tags for in-flight multicycle ops, with a variable read tap.
// Ports: clk/rst; push + push_tid/push_rd load stage 0 every cycle;
// tap selects the stage presented on tap_vld/tap_tid/tap_rd.
// An entry read at the tap is consumed: its valid bit does not propagate
// further, so a later switch to a longer tap never sees a stale tag.
module rfphoenix_tag_shreg
   import rfphoenix_mcalu_issue_pkg::*;
#(
   parameter int LAT_MAX = 16,
   parameter int RDW     = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  Tid                         push_tid,
   input  logic [RDW-1:0]             push_rd,
   input  logic [$clog2(LAT_MAX)-1:0] tap,
   output logic                       tap_vld,
   output Tid                         tap_tid,
   output logic [RDW-1:0]             tap_rd
);
   localparam int TAPW = $clog2(LAT_MAX);

   typedef struct packed {
      logic           vld;
      Tid             tid;
      logic [RDW-1:0] rd;
   } tag_t;

   tag_t stage_q [LAT_MAX];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LAT_MAX; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0].vld <= push;
         stage_q[0].tid <= push_tid;
         stage_q[0].rd  <= push_rd;
         for (int i = 1; i < LAT_MAX; i++) begin
            stage_q[i].vld <= stage_q[i-1].vld && (tap != TAPW'(i-1));
            stage_q[i].tid <= stage_q[i-1].tid;
            stage_q[i].rd  <= stage_q[i-1].rd;
         end
      end
   end

   assign tap_vld = stage_q[tap].vld;
   assign tap_tid = stage_q[tap].tid;
   assign tap_rd  = stage_q[tap].rd;

endmodule

// File: rtl/rfphoenix_mcalu_issue.sv
// rfphoenix_mcalu_issue: issue and writeback sequencer for the multicycle ALU.
// Ports: req_* valid/ready request (ir, operands a/b/c/imm, tid, rd);
// alu_* registered operands/instruction to the ALU, alu_o its result;
// res_* one-cycle result strobe with value, tid, rd and error flag
// (no backpressure); busy = ops in flight.
// The instruction register is only reloaded when the ALU output mux
// selection stays compatible with everything still in flight.
module rfphoenix_mcalu_issue
   import rfphoenix_mcalu_issue_pkg::*;
#(
   parameter int LAT_MAX = 16,
   parameter int RDW     = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           req_valid,
   output logic           req_ready,
   input  Instruction     req_ir,
   input  Value           req_a,
   input  Value           req_b,
   input  Value           req_c,
   input  Value           req_imm,
   input  Tid             req_tid,
   input  logic [RDW-1:0] req_rd,
   output Instruction     alu_ir,
   output Value           alu_a,
   output Value           alu_b,
   output Value           alu_c,
   output Value           alu_imm,
   input  Value           alu_o,
   output logic           res_valid,
   output Value           res_val,
   output Tid             res_tid,
   output logic [RDW-1:0] res_rd,
   output logic           res_err,
   output logic           busy
);
   localparam int TAPW = $clog2(LAT_MAX);
   localparam int CW   = $clog2(LAT_MAX + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_ERR} state_t;

   state_t         state, state_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   Tid             err_tid;
   logic [RDW-1:0] err_rd;

   McClass         req_cls;
   McLat           req_lat, held_lat;
   logic           key_eq, lat_eq, drain, accept, acc_mc;
   logic           tap_vld;
   Tid             tap_tid;
   logic [RDW-1:0] tap_rd;

   assign req_cls  = mcalu_class(req_ir);
   assign req_lat  = mcalu_lat(req_cls);
   assign held_lat = mcalu_lat(mcalu_class(alu_ir));
   assign key_eq   = mcalu_key(req_ir) == mcalu_key(alu_ir);
   assign lat_eq   = req_lat == held_lat;
   // The last in-flight op retires on this edge, so the held key is free
   // to change without waiting an extra cycle in IDLE.
   assign drain    = tap_vld && (cnt == CW'(1)) && (req_cls != MC_NONE);

   always_comb begin
      req_ready = 1'b0;
      case (state)
         S_IDLE:  req_ready = 1'b1;
         S_RUN:   req_ready = key_eq || (lat_eq && (cnt < CW'(LAT_MAX - 1))) || drain;
         default: req_ready = 1'b0;
      endcase
   end

   assign accept = req_valid && req_ready;
   assign acc_mc = accept && (req_cls != MC_NONE);
   assign cnt_nx = cnt + CW'(acc_mc) - CW'(tap_vld);

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = acc_mc ? S_RUN : S_ERR;
         S_RUN:   if (cnt_nx == '0) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Issue stage: operands and instruction presented to the ALU
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         alu_ir  <= '0;
         alu_a   <= '0;
         alu_b   <= '0;
         alu_c   <= '0;
         alu_imm <= '0;
         err_tid <= '0;
         err_rd  <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (acc_mc) begin
            alu_ir  <= req_ir;
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_c   <= req_c;
            alu_imm <= req_imm;
         end
         if (accept && !acc_mc) begin
            err_tid <= req_tid;
            err_rd  <= req_rd;
         end
      end
   end

   rfphoenix_tag_shreg #(
      .LAT_MAX (LAT_MAX),
      .RDW     (RDW)
   ) u_tags (
      .clk      (clk),
      .rst      (rst),
      .push     (acc_mc),
      .push_tid (req_tid),
      .push_rd  (req_rd),
      .tap      (TAPW'(held_lat)),
      .tap_vld  (tap_vld),
      .tap_tid  (tap_tid),
      .tap_rd   (tap_rd)
   );

   // Writeback stage: ERR reports the latched non-multicycle op
   assign res_err   = state == S_ERR;
   assign res_valid = res_err || tap_vld;
   assign res_val   = res_err ? '0 : alu_o;
   assign res_tid   = res_err ? err_tid : tap_tid;
   assign res_rd    = res_err ? err_rd : tap_rd;
   assign busy      = cnt != '0;

endmodule

// File: tb/tb_rfphoenix_mcalu_issue.sv
module tb_rfphoenix_mcalu_issue;
   import rfphoenix_mcalu_issue_pkg::*;

   localparam int RDW = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst, req_valid, req_ready;
   Instruction     req_ir, alu_ir;
   Value           req_a, req_b, req_c, req_imm;
   Value           alu_a, alu_b, alu_c, alu_imm, alu_o, res_val;
   Tid             req_tid, res_tid;
   logic [RDW-1:0] req_rd, res_rd;
   logic           res_valid, res_err, busy;

   rfphoenix_mcalu_issue #(.LAT_MAX(16), .RDW(RDW)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_ir(req_ir), .req_a(req_a), .req_b(req_b), .req_c(req_c), .req_imm(req_imm),
      .req_tid(req_tid), .req_rd(req_rd), .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b),
      .alu_c(alu_c), .alu_imm(alu_imm), .alu_o(alu_o), .res_valid(res_valid),
      .res_val(res_val), .res_tid(res_tid), .res_rd(res_rd), .res_err(res_err), .busy(busy)
   );

   typedef struct {
      bit is_rst; bit vld; Instruction ir;
      Value a; Value b; Value c; Value imm; Tid tid; logic [RDW-1:0] rd;
   } stim_t;
   typedef struct {
      int cyc; bit err; Value val; Tid tid; logic [RDW-1:0] rd;
   } exp_t;

   stim_t stim[$];
   exp_t  sb[$];
   int    infl[$];       // result cycles of multicycle ops in flight
   Value  sched[int];    // ALU stand-in: output value per cycle
   int    checks = 0, errors = 0, cyc = 0, err_cyc = -1;
   bit    mon_en = 0;
   Instruction held_ir;
   Value  held_a, held_b, held_c, held_imm;

   always @(posedge clk) cyc <= cyc + 1;

   // 0 none, 1 mul, 2 fma, 3 cvt, 4 est
   function automatic int kind_of(Instruction ir);
      int k = 0;
      if (ir.opcode == OP_MULI) k = 1;
      else if (ir.opcode inside {OP_FMA, OP_FMS, OP_FNMA, OP_FNMS}) k = 2;
      else if (ir.opcode == OP_R2 && ir.func == FN_MUL) k = 1;
      else if (ir.opcode == OP_R2 && ir.func inside {FN_FADD, FN_FSUB, FN_FMUL}) k = 2;
      else if (ir.opcode == OP_R1 && ir.func inside {FN_I2F, FN_F2I, FN_FTRUNC}) k = 3;
      else if (ir.opcode == OP_R1 && ir.func inside {FN_FRSQRTE, FN_FRES, FN_FSIGMOID}) k = 4;
      return k;
   endfunction

   function automatic int lat_of(Instruction ir);
      int k = kind_of(ir);
      return (k == 0) ? 0 : (k == 4) ? 6 : 8;
   endfunction

   function automatic Value alu_f(Instruction ir, Value a, Value b, Value c, Value imm);
      case (kind_of(ir))
         1: return (ir.opcode == OP_MULI) ? a * imm : a * b;
         2: return a + b + c;
         3: return a ^ b;
         4: return ~a;
         default: return '0;
      endcase
   endfunction

   function automatic logic [19:0] key_of(Instruction ir);
      return {ir.opcode, ir.func, ir.Rb};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
      end
   endtask

   function automatic Instruction mk_ir(logic [5:0] op, logic [7:0] fn, logic [5:0] rb);
      Instruction ir;
      ir.opcode = op; ir.func = fn; ir.Rb = rb;
      ir.Ra = 6'($urandom); ir.Rt = 6'($urandom);
      return ir;
   endfunction

   function automatic Instruction rand_ir();
      logic [5:0] rb = 6'($urandom_range(0, 1));
      case ($urandom_range(0, 11))
         0:  return mk_ir(OP_R2, FN_MUL, rb);
         1:  return mk_ir(OP_MULI, 8'h00, rb);
         2:  return mk_ir(OP_R2, FN_FADD, rb);
         3:  return mk_ir(OP_R2, FN_FSUB, rb);
         4:  return mk_ir(OP_FMA, 8'h00, rb);
         5:  return mk_ir(OP_FNMS, 8'h00, rb);
         6:  return mk_ir(OP_R1, FN_I2F, rb);
         7:  return mk_ir(OP_R1, FN_FTRUNC, rb);
         8:  return mk_ir(OP_R1, FN_FRES, rb);
         9:  return mk_ir(OP_R1, FN_FSIGMOID, rb);
         10: return mk_ir(OP_R2, FN_ADD, rb);
         default: return mk_ir(OP_ADDI, 8'h00, rb);
      endcase
   endfunction

   task automatic add_op(Instruction ir, Value a, Value b, Value c, Value imm, Tid tid, logic [RDW-1:0] rd);
      stim_t s;
      s.is_rst = 0; s.vld = 1; s.ir = ir; s.a = a; s.b = b; s.c = c; s.imm = imm;
      s.tid = tid; s.rd = rd;
      stim.push_back(s);
   endtask

   task automatic add_gap(int n, bit is_rst);
      stim_t s;
      for (int i = 0; i < n; i++) begin
         s.is_rst = is_rst; s.vld = 0; s.ir = rand_ir();
         s.a = $urandom; s.b = $urandom; s.c = $urandom; s.imm = $urandom;
         s.tid = Tid'($urandom); s.rd = 6'($urandom);
         stim.push_back(s);
      end
   endtask

   // Monitor: result strobes against the scoreboard
   always @(posedge clk) begin
      exp_t e;
      bit   ev;
      #3;
      if (mon_en) begin
         ev = (sb.size() > 0) && (sb[0].cyc == cyc);
         chk("res_valid", 64'(res_valid), 64'(ev));
         if (ev) begin
            e = sb.pop_front();
            chk("res_val", 64'(res_val), 64'(e.val));
            chk("res_tid", 64'(res_tid), 64'(e.tid));
            chk("res_rd", 64'(res_rd), 64'(e.rd));
            chk("res_err", 64'(res_err), 64'(e.err));
         end
      end
   end

   // Driver and reference model
   initial begin
      stim_t cur;
      bit    have = 0, rst_prev = 0, exp_rdy;
      int    waited = 0, drain = 0, n, lat;
      exp_t  e;

      rst = 1; req_valid = 0; req_ir = '0; req_a = '0; req_b = '0; req_c = '0;
      req_imm = '0; req_tid = '0; req_rd = '0; alu_o = '0;

      add_gap(2, 0);
      add_op(mk_ir(OP_R2, FN_MUL, 0), 7, 6, 0, 0, 4'd3, 6'd9);
      add_gap(12, 0);
      for (int t = 0; t < 5; t++)
         add_op(mk_ir(OP_R2, FN_FADD, 0), $urandom, $urandom, $urandom, 0, Tid'(t), 6'(10 + t));
      add_gap(12, 0);
      add_op(mk_ir(OP_R2, FN_FADD, 0), 100, 20, 3, 0, 4'd1, 6'd1);
      add_op(mk_ir(OP_R1, FN_FRES, 0), 32'h55, 0, 0, 0, 4'd2, 6'd2);
      add_gap(12, 0);
      add_op(mk_ir(OP_R2, FN_ADD, 0), 5, 5, 0, 0, 4'd5, 6'd20);
      add_gap(3, 0);
      for (int t = 0; t < 12; t++)
         add_op(mk_ir(OP_R2, FN_MUL, 0), $urandom, $urandom, 0, 0, Tid'(t), 6'(t));
      add_gap(12, 0);
      add_op(mk_ir(OP_R2, FN_MUL, 0), 3, 4, 0, 0, 4'd7, 6'd7);
      add_gap(2, 0);
      add_gap(1, 1);
      add_gap(12, 0);
      for (int i = 0; i < 700; i++) begin
         if ($urandom_range(0, 119) == 0) add_gap(1, 1);
         add_op(rand_ir(), $urandom, $urandom, $urandom, $urandom, Tid'($urandom), 6'($urandom));
         if ($urandom_range(0, 3) == 0) add_gap($urandom_range(1, 10), 0);
      end

      repeat (2) @(posedge clk);
      rst_prev = 1;
      while (stim.size() > 0 || have || drain < 20) begin
         @(posedge clk);
         #1;
         if (rst_prev) begin
            infl.delete(); sb.delete(); sched.delete(); err_cyc = -1;
            held_ir = '0; held_a = '0; held_b = '0; held_c = '0; held_imm = '0;
            mon_en = 1;
         end
         rst = 0; rst_prev = 0;
         alu_o = sched.exists(cyc) ? sched[cyc] : Value'($urandom);
         if (!have && stim.size() > 0) begin
            cur = stim.pop_front(); have = 1; waited = 0;
         end
         if (have && cur.is_rst) begin
            rst = 1; rst_prev = 1; req_valid = 0; have = 0;
         end else if (have) begin
            req_valid = cur.vld; req_ir = cur.ir; req_a = cur.a; req_b = cur.b;
            req_c = cur.c; req_imm = cur.imm; req_tid = cur.tid; req_rd = cur.rd;
         end else begin
            req_valid = 0; drain++;
         end

         @(negedge clk);
         while (infl.size() > 0 && infl[0] < cyc) void'(infl.pop_front());
         n = infl.size();
         lat = lat_of(req_ir);
         if (err_cyc == cyc) exp_rdy = 0;
         else if (n == 0) exp_rdy = 1;
         else exp_rdy = (key_of(req_ir) == key_of(held_ir)) || (lat == lat_of(held_ir)) ||
                        (n == 1 && infl[0] == cyc && lat != 0);
         chk("req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("busy", 64'(busy), 64'(n > 0));
         chk("alu_ir", 64'(alu_ir), 64'(held_ir));
         chk("alu_ops", {alu_a, alu_b ^ alu_c ^ alu_imm}, {held_a, held_b ^ held_c ^ held_imm});

         if (req_valid && req_ready) begin
            e.tid = req_tid; e.rd = req_rd;
            if (lat == 0) begin
               err_cyc = cyc + 1;
               e.cyc = cyc + 1; e.err = 1; e.val = '0;
            end else begin
               infl.push_back(cyc + lat + 1);
               e.cyc = cyc + lat + 1; e.err = 0;
               e.val = alu_f(req_ir, req_a, req_b, req_c, req_imm);
               held_ir = req_ir; held_a = req_a; held_b = req_b; held_c = req_c; held_imm = req_imm;
            end
            sb.push_back(e);
            have = 0;
         end else if (have && !cur.vld) begin
            have = 0;
         end else if (have) begin
            waited++;
            if (waited > 40) begin
               checks++; errors++;
               $display("FAIL stall_timeout cyc=%0d actual=not_accepted required=accepted", cyc);
               have = 0;
            end
         end

         // ALU stand-in: result appears LAT cycles after the operands it sees
         if (lat_of(alu_ir) != 0)
            sched[cyc + lat_of(alu_ir)] = alu_f(alu_ir, alu_a, alu_b, alu_c, alu_imm);
      end

      @(posedge clk);
      #5;
      chk("results_pending", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
